dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory load/store interface. It accepts one request at a time over a valid/ready handshake, waits a fixed, parameterised access latency, then applies the store or returns sign- or zero-extended load data over a valid/ready response channel. It lets the pipelined core, or a bus adapter in front of it, be tested against a memory with realistic multi-cycle latency, byte/halfword/word modes, and misalignment and range error reporting.

---
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between a load/store requester (master) and a data memory (slave).
interface dmem_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_mode;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    modport master (
        output req_valid, req_we, req_mode, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_mode, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one request in flight, byte/half/word access with
// sign/zero extension, misalignment, illegal-mode and range error reporting.
module dmem_responder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter int unsigned LATENCY     = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_we, w_we_nxt;
    logic [2:0]       r_mode, w_mode_nxt;
    logic [WIDTH-1:0] r_addr, w_addr_nxt;
    logic [WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic             r_resp_valid, w_resp_valid_nxt;
    logic [WIDTH-1:0] r_resp_rdata, w_resp_rdata_nxt;
    logic             r_resp_err, w_resp_err_nxt;
    logic             w_commit;

    logic [7:0]       r_mem [DEPTH_BYTES];

    logic [2:0]       w_size_m1;
    logic             w_mode_ok;
    logic             w_misalign;
    logic [WIDTH:0]   w_last;
    logic             w_oor;
    logic             w_err;
    logic [AW-1:0]    w_idx;
    logic [31:0]      w_word;
    logic [WIDTH-1:0] w_load;
    logic [3:0]       w_be;

    // Decode the captured request: size, legality and alignment.
    always_comb begin
        w_size_m1  = 3'd0;
        w_mode_ok  = 1'b1;
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        case (r_mode)
            3'b000: w_be = 4'b0001;
            3'b001: begin
                w_size_m1  = 3'd1;
                w_misalign = r_addr[0];
                w_be       = 4'b0011;
            end
            3'b010: begin
                w_size_m1  = 3'd3;
                w_misalign = |r_addr[1:0];
                w_be       = 4'b1111;
            end
            3'b100: w_mode_ok = !r_we;
            3'b101: begin
                w_size_m1  = 3'd1;
                w_misalign = r_addr[0];
                w_mode_ok  = !r_we;
            end
            default: w_mode_ok = 1'b0;
        endcase
        // Range check in WIDTH+1 bits so a high address never wraps into range.
        w_last = {1'b0, r_addr} + (WIDTH+1)'(w_size_m1);
        w_oor  = w_last >= (WIDTH+1)'(DEPTH_BYTES);
        w_err  = !w_mode_ok || w_misalign || w_oor;
    end

    // Little-endian read of four bytes starting at the request address, then extension.
    always_comb begin
        w_idx  = r_addr[AW-1:0];
        w_word = '0;
        for (int k = 0; k < 4; k++) begin
            w_word[8*k +: 8] = r_mem[AW'(w_idx + AW'(k))];
        end
        case (r_mode)
            3'b000:  w_load = WIDTH'($signed(w_word[7:0]));
            3'b001:  w_load = WIDTH'($signed(w_word[15:0]));
            3'b010:  w_load = WIDTH'(w_word);
            3'b100:  w_load = WIDTH'(w_word[7:0]);
            3'b101:  w_load = WIDTH'(w_word[15:0]);
            default: w_load = '0;
        endcase
    end

    // Next-state and response logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_we_nxt         = r_we;
        w_mode_nxt       = r_mode;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        w_commit         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    w_we_nxt    = bus.req_we;
                    w_mode_nxt  = bus.req_mode;
                    w_addr_nxt  = bus.req_addr;
                    w_wdata_nxt = bus.req_wdata;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    w_commit         = r_we && !w_err;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = w_err;
                    w_resp_rdata_nxt = (w_err || r_we) ? '0 : w_load;
                    w_state_nxt      = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_resp_rdata_nxt = '0;
                    w_resp_err_nxt   = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_mode       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_we         <= w_we_nxt;
            r_mode       <= w_mode_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    // Storage is never cleared; a reset on the commit edge suppresses the store.
    always_ff @(posedge clk) begin
        if (rst && w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[AW'(w_idx + AW'(k))] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) && rst;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=2 instance for data-path checks and a LATENCY=4 instance for reset abort.
module tb_dmem_responder;
    logic        clk;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        o_req_ready;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;

    int n_cmp;
    int n_err;
    bit got_any;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    dmem_if #(.WIDTH(32)) ifa ();
    dmem_if #(.WIDTH(32)) ifb ();

    assign ifa.req_valid  = req_valid && !sel;
    assign ifb.req_valid  = req_valid && sel;
    assign ifa.req_we     = req_we;
    assign ifb.req_we     = req_we;
    assign ifa.req_mode   = req_mode;
    assign ifb.req_mode   = req_mode;
    assign ifa.req_addr   = req_addr;
    assign ifb.req_addr   = req_addr;
    assign ifa.req_wdata  = req_wdata;
    assign ifb.req_wdata  = req_wdata;
    assign ifa.resp_ready = resp_ready;
    assign ifb.resp_ready = resp_ready;

    assign o_req_ready  = sel ? ifb.req_ready  : ifa.req_ready;
    assign o_resp_valid = sel ? ifb.resp_valid : ifa.resp_valid;
    assign o_resp_rdata = sel ? ifb.resp_rdata : ifa.resp_rdata;
    assign o_resp_err   = sel ? ifb.resp_err   : ifa.resp_err;

    dmem_responder #(.WIDTH(32), .DEPTH_BYTES(4096), .LATENCY(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dmem_responder #(.WIDTH(32), .DEPTH_BYTES(4096), .LATENCY(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction: push the expectation, drive, then pop and compare when the response shows.
    task automatic txn(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                       input int hold, input string tag);
        exp_t e;
        int   lat;
        bit   got;
        sb.push_back('{tag, exp_rd, exp_err});
        @(negedge clk);
        resp_ready = (hold == 0);
        req_valid  = 1'b1;
        req_we     = we;
        req_mode   = mode;
        req_addr   = addr;
        req_wdata  = wdata;
        check({tag, ".req_ready"}, 32'(o_req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_mode  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            got = o_resp_valid;
        end
        e = sb.pop_front();
        check({e.tag, ".latency"}, 32'(lat), sel ? 32'd4 : 32'd2);
        if (!got) return;
        check({e.tag, ".rdata"}, o_resp_rdata, e.rdata);
        check({e.tag, ".err"}, 32'(o_resp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({e.tag, ".hold_valid"}, 32'(o_resp_valid), 32'd1);
            check({e.tag, ".hold_rdata"}, o_resp_rdata, e.rdata);
            check({e.tag, ".hold_err"}, 32'(o_resp_err), 32'(e.err));
            check({e.tag, ".hold_ready"}, 32'(o_req_ready), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clk);
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({e.tag, ".done_valid"}, 32'(o_resp_valid), 32'd0);
        check({e.tag, ".done_rdata"}, o_resp_rdata, 32'd0);
        check({e.tag, ".done_ready"}, 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_mode   = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        repeat (2) begin
            @(negedge clk);
            check("rst.req_ready", 32'(o_req_ready), 32'd0);
            check("rst.resp_valid", 32'(o_resp_valid), 32'd0);
            check("rst.resp_rdata", o_resp_rdata, 32'd0);
            check("rst.resp_err", 32'(o_resp_err), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle.req_ready", 32'(o_req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("idle.resp_valid", 32'(o_resp_valid), 32'd0);

        // Word round trip and extensions
        txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, "sw_10");
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, "lw_10");
        txn(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 0, "lb_13");
        txn(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 0, "lbu_13");
        txn(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 0, "lh_12");
        txn(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0, 0, "lhu_12");

        // Sub-word store merge
        txn(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 0, "sw_20");
        txn(1'b1, 3'b000, 32'h21, 32'h1234_5680, 32'h0, 1'b0, 0, "sb_21");
        txn(1'b1, 3'b001, 32'h22, 32'hAAAA_8001, 32'h0, 1'b0, 0, "sh_22");
        txn(1'b0, 3'b010, 32'h20, 32'h0, 32'h8001_8000, 1'b0, 0, "lw_20");

        // Error cases
        txn(1'b1, 3'b010, 32'h08, 32'h1122_3344, 32'h0, 1'b0, 0, "sw_08");
        txn(1'b1, 3'b010, 32'h04, 32'h0102_0304, 32'h0, 1'b0, 0, "sw_04");
        txn(1'b0, 3'b001, 32'h05, 32'h0, 32'h0, 1'b1, 0, "lh_05_mis");
        txn(1'b1, 3'b010, 32'h06, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, "sw_06_mis");
        txn(1'b0, 3'b010, 32'h04, 32'h0, 32'h0102_0304, 1'b0, 0, "lw_04_kept");
        txn(1'b0, 3'b010, 32'hFFE, 32'h0, 32'h0, 1'b1, 0, "lw_ffe_oor");
        txn(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 0, "mode_011");
        txn(1'b1, 3'b100, 32'h08, 32'h0000_00AA, 32'h0, 1'b1, 0, "sbu_08_ill");
        txn(1'b0, 3'b010, 32'h08, 32'h0, 32'h1122_3344, 1'b0, 0, "lw_08_kept");
        txn(1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 1'b1, 0, "lb_1000_oor");
        txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 1'b1, 0, "lw_hi_nowrap");

        // Top of memory stays in range
        txn(1'b1, 3'b010, 32'hFFC, 32'hA5A5_5A5A, 32'h0, 1'b0, 0, "sw_ffc");
        txn(1'b0, 3'b000, 32'hFFF, 32'h0, 32'hFFFF_FFA5, 1'b0, 0, "lb_fff");

        // Backpressure
        txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, "bp_lw_10");

        // Reset while a LATENCY=4 store is in flight
        sel = 1'b1;
        txn(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 0, "b_sw_30");
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_mode  = 3'b010;
        req_addr  = 32'h30;
        req_wdata = 32'h0000_0055;
        check("abort.req_ready", 32'(o_req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort.resp_valid", 32'(o_resp_valid), 32'd0);
        check("abort.req_ready", 32'(o_req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        got_any = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            got_any = got_any | o_resp_valid;
        end
        check("abort.no_resp", 32'(got_any), 32'd0);
        txn(1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 0, "b_lw_30");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
